// File: rtl/cpu_pkg.sv
// Shared CPU-core constants and helpers: default data/address widths, register count, packed-port slicing.
// Latency: none (types and functions only); backpressure: none.
package cpu_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    function automatic int nreg(input int aw);
        return 1 << aw;
    endfunction

    // Low bit of lane k in a packed bus of lanes each w bits wide.
    function automatic int lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register pending-producer bits: a reserve sets a bit and a write clears it; same-cycle writes are bypassed onto rbusy.
// Latency: rbusy is combinational from raddr; bits update on the rising edge. Backpressure: none.
module regfile_busy_tracker
    import cpu_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int NR = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            we0,
    input  logic [AW-1:0]   waddr0,
    input  logic            we1,
    input  logic [AW-1:0]   waddr1,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_addr,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR-1:0]   rbusy
);
    localparam int NREG = nreg(AW);

    logic [NREG-1:0] busy;

    // A reserve beats a clear: the write retires the old producer while a new one issues.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int i = 1; i < NREG; i++) begin
                if (rsv_valid && rsv_addr == AW'(i))
                    busy[i] <= 1'b1;
                else if ((we0 && waddr0 == AW'(i)) || (we1 && waddr1 == AW'(i)))
                    busy[i] <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NR; k++) begin : g_rbusy
        logic [AW-1:0] a;
        logic          wr_hit;
        logic          rsv_hit;
        assign a       = raddr[lo(k, AW) +: AW];
        assign wr_hit  = (we0 && waddr0 == a) || (we1 && waddr1 == a);
        assign rsv_hit = rsv_valid && rsv_addr == a;
        assign rbusy[k] = !reset && (a != '0) && (wr_hit ? rsv_hit : busy[a]);
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-write, NR-read register file with zero register, write-to-read bypass and a per-register busy scoreboard.
// Latency: reads are combinational (same-cycle bypass); writes land on the rising edge. Backpressure: none.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int NR       = 2,
    parameter int TEST_REG = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    output logic [NR-1:0]    rbusy,
    input  logic             we0,
    input  logic             we1,
    input  logic [AW-1:0]    waddr0,
    input  logic [AW-1:0]    waddr1,
    input  logic [DW-1:0]    wdata0,
    input  logic [DW-1:0]    wdata1,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_addr,
    output logic [DW-1:0]    test_data
);
    localparam int NREG = nreg(AW);

    logic [DW-1:0] regs [NREG];

    // Register 0 is cleared by reset and never written afterwards; port 1 wins a same-address collision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (we1 && waddr1 == AW'(i))
                    regs[i] <= wdata1;
                else if (we0 && waddr0 == AW'(i))
                    regs[i] <= wdata0;
            end
        end
    end

    for (genvar k = 0; k < NR; k++) begin : g_read
        logic [AW-1:0] a;
        assign a = raddr[lo(k, AW) +: AW];
        assign rdata[lo(k, DW) +: DW] =
            (reset || a == '0)       ? '0     :
            (we1 && waddr1 == a)     ? wdata1 :
            (we0 && waddr0 == a)     ? wdata0 :
                                       regs[a];
    end

    assign test_data = regs[AW'(TEST_REG)];

    regfile_busy_tracker #(
        .AW (AW),
        .NR (NR)
    ) u_busy (
        .clock     (clock),
        .reset     (reset),
        .we0       (we0),
        .waddr0    (waddr0),
        .we1       (we1),
        .waddr1    (waddr1),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .raddr     (raddr),
        .rbusy     (rbusy)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, write priority, zero register, scoreboard and async reset.
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic [31:0] test_data;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    regfile_scoreboard #(.DW(32), .AW(5), .NR(2), .TEST_REG(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .we0       (we0),
        .we1       (we1),
        .waddr0    (waddr0),
        .waddr1    (waddr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .test_data (test_data)
    );

    task automatic idle();
        we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
        rsv_valid = 0; rsv_addr = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle(); raddr = {5'd3, 5'd5};
        repeat (2) @(negedge clock);
        total++; if (rdata !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 64'h0); end
        total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL reset_rbusy got=%b exp=%b", rbusy, 2'b00); end
        total++; if (test_data !== 32'h0) begin bad++; $display("FAIL reset_test_data got=%h exp=%h", test_data, 32'h0); end
        reset = 0;
    endtask

    task automatic test_write_bypass();
        @(negedge clock);
        we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; raddr = {5'd5, 5'd5};
        #1;
        total++; if (rdata[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_p0 got=%h exp=%h", rdata[31:0], 32'hDEADBEEF); end
        total++; if (rdata[63:32] !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_p1 got=%h exp=%h", rdata[63:32], 32'hDEADBEEF); end
        @(negedge clock); idle(); #1;
        total++; if (rdata[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL stored_x5 got=%h exp=%h", rdata[31:0], 32'hDEADBEEF); end
        total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL nonbusy_write got=%b exp=%b", rbusy, 2'b00); end
    endtask

    task automatic test_dual_write();
        @(negedge clock);
        we0 = 1; waddr0 = 7; wdata0 = 32'h11; we1 = 1; waddr1 = 7; wdata1 = 32'h22;
        raddr = {5'd5, 5'd7};
        #1;
        total++; if (rdata[31:0] !== 32'h22) begin bad++; $display("FAIL dual_bypass got=%h exp=%h", rdata[31:0], 32'h22); end
        @(negedge clock); idle(); #1;
        total++; if (rdata[31:0] !== 32'h22) begin bad++; $display("FAIL dual_stored got=%h exp=%h", rdata[31:0], 32'h22); end
        total++; if (rdata[63:32] !== 32'hDEADBEEF) begin bad++; $display("FAIL p1_x5_kept got=%h exp=%h", rdata[63:32], 32'hDEADBEEF); end
    endtask

    task automatic test_zero_reg();
        @(negedge clock);
        we0 = 1; waddr0 = 0; wdata0 = 32'hFFFFFFFF; rsv_valid = 1; rsv_addr = 0;
        raddr = {5'd0, 5'd0};
        #1;
        total++; if (rdata !== 64'h0) begin bad++; $display("FAIL x0_bypass got=%h exp=%h", rdata, 64'h0); end
        total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL x0_rbusy_same got=%b exp=%b", rbusy, 2'b00); end
        @(negedge clock); idle(); #1;
        total++; if (rdata[31:0] !== 32'h0) begin bad++; $display("FAIL x0_stored got=%h exp=%h", rdata[31:0], 32'h0); end
        total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL x0_rbusy_after got=%b exp=%b", rbusy, 2'b00); end
    endtask

    task automatic test_busy();
        @(negedge clock);
        rsv_valid = 1; rsv_addr = 9; raddr = {5'd7, 5'd9};
        @(negedge clock); idle(); #1;
        total++; if (rbusy !== 2'b01) begin bad++; $display("FAIL rsv_x9_busy got=%b exp=%b", rbusy, 2'b01); end
        we0 = 1; waddr0 = 9; wdata0 = 32'h55; #1;
        total++; if (rbusy[0] !== 1'b0) begin bad++; $display("FAIL wr_clears_rbusy got=%b exp=%b", rbusy[0], 1'b0); end
        total++; if (rdata[31:0] !== 32'h55) begin bad++; $display("FAIL x9_bypass got=%h exp=%h", rdata[31:0], 32'h55); end
        @(negedge clock); idle(); #1;
        total++; if (rbusy[0] !== 1'b0) begin bad++; $display("FAIL x9_cleared got=%b exp=%b", rbusy[0], 1'b0); end
        total++; if (rdata[31:0] !== 32'h55) begin bad++; $display("FAIL x9_stored got=%h exp=%h", rdata[31:0], 32'h55); end
    endtask

    task automatic test_rsv_write_same();
        @(negedge clock);
        rsv_valid = 1; rsv_addr = 9; we0 = 1; waddr0 = 9; wdata0 = 32'h66;
        raddr = {5'd7, 5'd9};
        #1;
        total++; if (rbusy[0] !== 1'b1) begin bad++; $display("FAIL rsv_wr_rbusy got=%b exp=%b", rbusy[0], 1'b1); end
        @(negedge clock); idle(); #1;
        total++; if (rbusy[0] !== 1'b1) begin bad++; $display("FAIL rsv_wins got=%b exp=%b", rbusy[0], 1'b1); end
        total++; if (rdata[31:0] !== 32'h66) begin bad++; $display("FAIL rsv_wr_data got=%h exp=%h", rdata[31:0], 32'h66); end
    endtask

    task automatic test_test_data();
        @(negedge clock);
        we1 = 1; waddr1 = 3; wdata1 = 32'h5D; #1;
        total++; if (test_data !== 32'h0) begin bad++; $display("FAIL test_data_no_bypass got=%h exp=%h", test_data, 32'h0); end
        @(negedge clock); idle(); #1;
        total++; if (test_data !== 32'h5D) begin bad++; $display("FAIL test_data_x3 got=%h exp=%h", test_data, 32'h5D); end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        rsv_valid = 1; rsv_addr = 12;
        @(negedge clock); idle(); raddr = {5'd12, 5'd3}; #1;
        total++; if (rbusy !== 2'b10) begin bad++; $display("FAIL pre_reset_rbusy got=%b exp=%b", rbusy, 2'b10); end
        total++; if (rdata[31:0] !== 32'h5D) begin bad++; $display("FAIL pre_reset_x3 got=%h exp=%h", rdata[31:0], 32'h5D); end
        we0 = 1; waddr0 = 4; wdata0 = 32'hAB; rsv_valid = 1; rsv_addr = 4;
        #1 reset = 1; #1;
        total++; if (test_data !== 32'h0) begin bad++; $display("FAIL mid_reset_test_data got=%h exp=%h", test_data, 32'h0); end
        total++; if (rdata !== 64'h0) begin bad++; $display("FAIL mid_reset_rdata got=%h exp=%h", rdata, 64'h0); end
        total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL mid_reset_rbusy got=%b exp=%b", rbusy, 2'b00); end
        @(negedge clock); idle(); reset = 0; raddr = {5'd12, 5'd4}; #1;
        total++; if (rdata[31:0] !== 32'h0) begin bad++; $display("FAIL reset_drop_write got=%h exp=%h", rdata[31:0], 32'h0); end
        total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL reset_drop_rsv got=%b exp=%b", rbusy, 2'b00); end
        raddr = {5'd9, 5'd3}; #1;
        total++; if (rdata !== 64'h0) begin bad++; $display("FAIL post_reset_clear got=%h exp=%h", rdata, 64'h0); end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_dual_write();
        test_zero_reg();
        test_busy();
        test_rsv_write_same();
        test_test_data();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
